cla_serial_wordadd: RTL and testbench

//  Byte-serial multi-word adder wrapped around one 8-bit cla_adder instance.

---
 rtl/cla_serial_wordadd.sv | 160 ++++++++++++++++
 tb/tb_cla_serial_wordadd.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/cla_serial_wordadd.sv
// Byte-serial NBYTES*8-bit adder reusing one 8-bit carry-lookahead slice.
// Latency: accept on edge 0, rsp_valid high after edge NBYTES; one op per NBYTES+2 cycles.
// Backpressure: req_ready low from accept until response handshake; result held while rsp_ready=0.
//
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_a/req_b/req_cin request side;
//        rsp_valid/rsp_ready/rsp_sum/rsp_cout response side; busy high in ADD or DONE.
// Optional: define CLA_SERIAL_OVF_EN to add rsp_ovf (two's-complement overflow of the full word).

module cla_adder (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] s_o,
  output logic       cout_o
);
  logic [7:0] g, p;
  logic [8:0] c;

  // Expanded 4-bit lookahead; returns carries into bits 1..4 of the group.
  function automatic logic [3:0] cla4(input logic [3:0] gg, input logic [3:0] pp, input logic ci);
    logic [3:0] co;
    co[0] = gg[0] | (pp[0] & ci);
    co[1] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
    co[2] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & ci);
    co[3] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
          | (pp[3] & pp[2] & pp[1] & pp[0] & ci);
    return co;
  endfunction

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  always_comb begin
    c = '0;
    c[0] = cin_i;
    c[4:1] = cla4(g[3:0], p[3:0], c[0]);
    c[8:5] = cla4(g[7:4], p[7:4], c[4]);
  end

  assign s_o    = p ^ c[7:0];
  assign cout_o = c[8];
endmodule

module cla_serial_wordadd #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [8*NBYTES-1:0] req_a,
  input  logic [8*NBYTES-1:0] req_b,
  input  logic                req_cin,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [8*NBYTES-1:0] rsp_sum,
  output logic                rsp_cout,
`ifdef CLA_SERIAL_OVF_EN
  output logic                rsp_ovf,
`endif
  output logic                busy
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t          state_q;
  logic [W-1:0]    a_sh_q, b_sh_q, sum_q;
  logic            carry_q;
  logic [CW-1:0]   cnt_q;
  logic            req_ready_q, rsp_valid_q, rsp_cout_q;
  logic [7:0]      add_s;
  logic            add_cout;
`ifdef CLA_SERIAL_OVF_EN
  logic            ovf_q;
`endif

  cla_adder u_cla (
    .a_i    (a_sh_q[7:0]),
    .b_i    (b_sh_q[7:0]),
    .cin_i  (carry_q),
    .s_o    (add_s),
    .cout_o (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_cout_q  <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            a_sh_q      <= req_a;
            b_sh_q      <= req_b;
            carry_q     <= req_cin;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            state_q     <= S_ADD;
          end else begin
            // Also covers the first edge after reset release.
            req_ready_q <= 1'b1;
          end
        end
        S_ADD: begin
          // Result fills from the top so byte 0 lands at the bottom after NBYTES shifts.
          sum_q   <= {add_s, sum_q[W-1:8]};
          a_sh_q  <= {8'h00, a_sh_q[W-1:8]};
          b_sh_q  <= {8'h00, b_sh_q[W-1:8]};
          carry_q <= add_cout;
          if (cnt_q == CW'(NBYTES - 1)) begin
            rsp_cout_q  <= add_cout;
            rsp_valid_q <= 1'b1;
`ifdef CLA_SERIAL_OVF_EN
            ovf_q       <= (a_sh_q[7] == b_sh_q[7]) && (add_s[7] != a_sh_q[7]);
`endif
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
`ifdef CLA_SERIAL_OVF_EN
            ovf_q       <= 1'b0;
`endif
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign busy      = (state_q != S_IDLE);
`ifdef CLA_SERIAL_OVF_EN
  assign rsp_ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_cla_serial_wordadd.sv
// Directed bench for cla_serial_wordadd at NBYTES=4.
// Drives and samples 1ns after each rising edge.
// Response-side backpressure exercised with rsp_ready held low in DONE.

module tb_cla_serial_wordadd;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         req_cin = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         busy;
`ifdef CLA_SERIAL_OVF_EN
  logic         rsp_ovf;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  cla_serial_wordadd #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
`ifdef CLA_SERIAL_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for req_ready, then performs the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input string tag);
    int n = 0;
    req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_ready"}, req_ready, 1);
    step();
    req_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1);
  endtask

  // Checks exact latency, result and the response handshake. exp_ovf < 0 skips the overflow check.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] exp_sum, input logic exp_cout, input int exp_ovf,
                        input string tag);
    send(a, b, cin, tag);
    repeat (NB - 1) step();
    chk({tag, "_early"}, rsp_valid, 0);
    step();
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_sum"}, rsp_sum, exp_sum);
    chk({tag, "_cout"}, rsp_cout, exp_cout);
`ifdef CLA_SERIAL_OVF_EN
    if (exp_ovf >= 0) chk({tag, "_ovf"}, rsp_ovf, exp_ovf[0]);
`endif
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, rsp_valid, 0);
    chk({tag, "_rdy_back"}, req_ready, 1);
  endtask

  initial begin
    // Reset: three cycles low, every output zero.
    #2 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cout", rsp_cout, 0);
    chk("rst_sum", rsp_sum, 0);
    rst_n = 1'b1;
    chk("rel_ready_hold", req_ready, 0);
    step();
    chk("rel_ready_one_edge", req_ready, 1);

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 0, "wrap");
    run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 0, "mix");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, 1, "msb");

    // Backpressure: result held in DONE while a new request waits.
    send(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, "bp");
    repeat (NB) step();
    chk("bp_valid", rsp_valid, 1);
    req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF; req_cin = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_sum_hold", rsp_sum, 32'hFFFF_FFFF);
      chk("bp_cout_hold", rsp_cout, 0);
      chk("bp_no_ready", req_ready, 0);
      chk("bp_valid_hold", rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_idle", busy, 0);
    chk("bp_ready_back", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("bp_second_accept", busy, 1);
    repeat (NB) step();
    chk("bp2_valid", rsp_valid, 1);
    chk("bp2_sum", rsp_sum, 32'hFFFF_FFFF);
    chk("bp2_cout", rsp_cout, 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset during the second ADD cycle aborts the operation.
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, "abort");
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_sum", rsp_sum, 0);
    for (int i = 0; i < NB + 2; i++) begin
      step();
      chk("abort_no_valid", rsp_valid, 0);
    end
    rst_n = 1'b1;
    step();
    chk("abort_rel_ready", req_ready, 1);
    chk("abort_no_valid_after", rsp_valid, 0);
    run_op(32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0005, 1'b0, 0, "post");

`ifdef CLA_SERIAL_OVF_EN
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1, "ovf_pos");
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 0, "ovf_none");
    chk("ovf_cleared", rsp_ovf, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
